// File: rtl/lock_ctrl_pkg.sv
// Shared types for the two-button combination lock controller.
// State encodings, digit values and the timer-width helper.
package lock_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTRY   = 3'd1,
      S_OPEN    = 3'd2,
      S_PROG    = 3'd3,
      S_LOCKOUT = 3'd4
   } state_e;

   localparam logic DIGIT0 = 1'b0;
   localparam logic DIGIT1 = 1'b1;

   function automatic int tmr_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/lock_ctrl_btn_edge.sv
// Rising-edge press detector for the two lock buttons.
// Registers start high so a button held through reset is not a press.
module btn_edge
   import lock_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic b0,
   input  logic b1,
   output logic press0,
   output logic press1,
   output logic digit_valid,
   output logic digit
);

   logic b0_q;
   logic b1_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         b0_q <= 1'b1;
         b1_q <= 1'b1;
      end else begin
         b0_q <= b0;
         b1_q <= b1;
      end
   end

   assign press0 = b0 & ~b0_q;
   assign press1 = b1 & ~b1_q;

   // simultaneous presses cancel out
   assign digit_valid = press0 ^ press1;
   assign digit       = press1 ? DIGIT1 : DIGIT0;

endmodule

// File: rtl/lock_ctrl.sv
// Combination lock sequencer: code entry, open hold,
// reprogramming and failed-attempt lockout.
module lock_ctrl
   import lock_ctrl_pkg::*;
#(
   parameter int                  CODE_LEN       = 5,
   parameter logic [CODE_LEN-1:0] RESET_CODE     = 5'b10010,
   parameter int                  MAX_FAIL       = 3,
   parameter int                  OPEN_CYCLES    = 500,
   parameter int                  LOCKOUT_CYCLES = 1000,
   parameter int                  TIMEOUT_CYCLES = 200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       b0,
   input  logic       b1,
   input  logic       prog,
   output logic       unlock,
   output logic       alarm,
   output logic [2:0] fail_cnt,
   output logic [2:0] debugstate
);

   localparam int TW = tmr_w(OPEN_CYCLES, LOCKOUT_CYCLES, TIMEOUT_CYCLES);
   localparam int CW = $clog2(CODE_LEN + 1);

   localparam logic [TW-1:0] OPEN_END = TW'(OPEN_CYCLES - 1);
   localparam logic [TW-1:0] LOCK_END = TW'(LOCKOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_END   = TW'(TIMEOUT_CYCLES - 1);

   state_e              state_q, state_d;
   logic [CODE_LEN-1:0] shift_q, shift_d;
   logic [CODE_LEN-1:0] code_q, code_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [TW-1:0]       tmr_q, tmr_d;
   logic [2:0]          fail_q, fail_d;
   logic                unlock_q, alarm_q;

   logic                dv, digit;
   logic                p0_unused, p1_unused;
   logic [CODE_LEN-1:0] entry_nx;
   logic [2:0]          fail_inc;
   logic                last;

   btn_edge u_btn (
      .clk         (clk),
      .rst         (rst),
      .b0          (b0),
      .b1          (b1),
      .press0      (p0_unused),
      .press1      (p1_unused),
      .digit_valid (dv),
      .digit       (digit)
   );

   assign entry_nx = {shift_q[CODE_LEN-2:0], digit};
   assign fail_inc = fail_q + 3'd1;
   assign last     = (cnt_q == CW'(CODE_LEN - 1));

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      code_d  = code_q;
      cnt_d   = cnt_q;
      fail_d  = fail_q;
      tmr_d   = tmr_q + 1'b1;
      unique case (state_q)
         S_IDLE: begin
            tmr_d = '0;
            if (dv) begin
               shift_d = {{(CODE_LEN-1){1'b0}}, digit};
               cnt_d   = CW'(1);
               state_d = S_ENTRY;
            end
         end
         S_ENTRY, S_PROG: begin
            if (dv) begin
               tmr_d = '0;
               if (!last) begin
                  shift_d = entry_nx;
                  cnt_d   = cnt_q + 1'b1;
               end else if (state_q == S_PROG) begin
                  code_d  = entry_nx;
                  state_d = S_IDLE;
               end else if (entry_nx == code_q) begin
                  fail_d  = '0;
                  state_d = S_OPEN;
               end else begin
                  fail_d  = fail_inc;
                  state_d = (fail_inc == 3'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
               end
            end else if (tmr_q == TO_END) begin
               state_d = S_IDLE;
            end
         end
         S_OPEN: begin
            // expiry beats prog, prog beats a manual relock
            if (tmr_q == OPEN_END) state_d = S_IDLE;
            else if (prog)         state_d = S_PROG;
            else if (dv)           state_d = S_IDLE;
         end
         S_LOCKOUT: begin
            if (tmr_q == LOCK_END) begin
               fail_d  = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != state_q) tmr_d = '0;
      if (state_d != S_ENTRY && state_d != S_PROG) begin
         shift_d = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         code_q   <= RESET_CODE;
         cnt_q    <= '0;
         tmr_q    <= '0;
         fail_q   <= '0;
         unlock_q <= 1'b0;
         alarm_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         code_q   <= code_d;
         cnt_q    <= cnt_d;
         tmr_q    <= tmr_d;
         fail_q   <= fail_d;
         unlock_q <= (state_d == S_OPEN);
         alarm_q  <= (state_d == S_LOCKOUT);
      end
   end

   assign unlock     = unlock_q;
   assign alarm      = alarm_q;
   assign fail_cnt   = fail_q;
   assign debugstate = state_q;

endmodule
